// File: rtl/mux_nto1_rr.sv
// N-input, WIDTH-bit multiplexer with a registered output stage and valid/ready
// handshakes; channel choice is either a fixed select or a round-robin scan.
module mux_nto1_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  last_q, last_d;

    logic             can_load;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer_in;

    assign can_load = !out_valid_q || out_ready;

    // Grant: fixed select, or round-robin scan of channels above last then wrapping to 0..last
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (!mode) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (sel == SELW'(k) && in_valid[k]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SELW'(k);
                end
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!gnt_valid && in_valid[k] && SELW'(k) > last_q) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SELW'(k);
                end
            end
            for (int unsigned k = 0; k < N; k++) begin
                if (!gnt_valid && in_valid[k] && SELW'(k) <= last_q) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SELW'(k);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (gnt_idx == SELW'(k)) begin
                gnt_data    = in_data[k*WIDTH +: WIDTH];
                in_ready[k] = !rst && can_load && gnt_valid;
            end
        end
    end

    assign xfer_in = !rst && can_load && gnt_valid;

    // Output stage: load on input transfer, otherwise drop valid once the word drains
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer_in) begin
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                last_d = gnt_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            last_q      <= LAST_RST;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: a 4-channel instance driven from a vector table
// plus hand sequences for reset and a 3-channel instance.
module tb_mux_nto1_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic        out_ready;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_nto1_rr #(.WIDTH(8), .N(4), .SELW(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_nto1_rr #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ord;
        logic [3:0]  exp_rdy;
        logic        exp_vld;
        logic [1:0]  exp_ch;
        logic [7:0]  exp_data;
    } vec_t;

    localparam logic [31:0] D  = 32'h1312_1110;
    localparam logic [31:0] D2 = 32'h13A5_1110;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b1; sel = '0; out_ready = 1'b1;
        in_data = D; in_valid = 4'hF;
        in_data3 = 24'h22_2120; in_valid3 = 3'b111;

        vecs[0]  = '{1'b1, 2'd0, 4'hF, D,  1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        vecs[1]  = '{1'b1, 2'd0, 4'hF, D,  1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        vecs[2]  = '{1'b1, 2'd0, 4'hF, D,  1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        vecs[3]  = '{1'b1, 2'd0, 4'hF, D,  1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        vecs[4]  = '{1'b1, 2'd0, 4'hF, D,  1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        vecs[5]  = '{1'b1, 2'd0, 4'hF, D,  1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        vecs[6]  = '{1'b0, 2'd2, 4'hF, D2, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        vecs[7]  = '{1'b0, 2'd2, 4'hB, D2, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA5};
        vecs[8]  = '{1'b1, 2'd0, 4'hF, D,  1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        vecs[9]  = '{1'b1, 2'd0, 4'hF, D,  1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
        vecs[10] = '{1'b1, 2'd0, 4'h3, D2, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
        vecs[11] = '{1'b0, 2'd0, 4'hF, D,  1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
        vecs[12] = '{1'b1, 2'd0, 4'hF, D,  1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        vecs[13] = '{1'b1, 2'd0, 4'hA, D,  1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        vecs[14] = '{1'b1, 2'd0, 4'hA, D,  1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        vecs[15] = '{1'b1, 2'd0, 4'hA, D,  1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        vecs[16] = '{1'b1, 2'd0, 4'hA, D,  1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        vecs[17] = '{1'b1, 2'd0, 4'h2, D,  1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        vecs[18] = '{1'b1, 2'd0, 4'h2, D,  1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        vecs[19] = '{1'b1, 2'd0, 4'h0, D,  1'b1, 4'b0000, 1'b0, 2'd1, 8'h11};

        // Reset held two cycles with every channel valid
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            step();
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_data", 32'(out_data), 32'h0);
            chk("rst_out_ch", 32'(out_ch), 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            mode = vecs[i].mode; sel = vecs[i].sel; in_valid = vecs[i].valid;
            in_data = vecs[i].data; out_ready = vecs[i].ord;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            step();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
            chk($sformatf("v%0d_out_ch", i), 32'(out_ch), 32'(vecs[i].exp_ch));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
        end

        // Reset mid-operation with a held word and out_ready low; pointer was on channel 1
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        step();
        chk("mid_load_ch", 32'(out_ch), 32'd1);
        out_ready = 1'b0; in_valid = 4'hF; rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
        step();
        chk("post_rst_out_ch", 32'(out_ch), 32'd0);
        chk("post_rst_out_data", 32'(out_data), 32'h10);

        // Three-channel instance: round-robin wraps 2 -> 0, sel=3 never grants
        in_valid = 4'h0;
        rst = 1'b1;
        step();
        rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("n3_rr%0d_ch", i), 32'(out_ch3), 32'(i % 3));
            chk($sformatf("n3_rr%0d_data", i), 32'(out_data3), 32'h20 + 32'(i % 3));
        end
        mode = 1'b0; sel = 2'd2;
        #1;
        chk("n3_sel2_in_ready", 32'(in_ready3), 32'b100);
        step();
        chk("n3_sel2_out_ch", 32'(out_ch3), 32'd2);
        sel = 2'd3;
        #1;
        chk("n3_sel3_in_ready", 32'(in_ready3), 32'h0);
        step();
        chk("n3_sel3_out_valid", 32'(out_valid3), 32'h0);
        chk("n3_sel3_out_ch_kept", 32'(out_ch3), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
